// File: rtl/irs_block_manager.sv
// IRS write block supplier: hands block addresses to the quad write controller and,
// when IRS_BLOCK_MANAGER_LOCK_EN is defined, skips pairs held locked for readout.
module irs_block_manager #(
   parameter int LOCK_SLOTS = 8
) (
   input  logic       clk_i,
   input  logic       rst_n_i,
   input  logic       wr_phase_i,
   input  logic       wr_ack_i,
   output logic [8:0] block_o,
   output logic [7:0] history_pair_o,
   output logic       history_strb_o,
   input  logic       lock_req_i,
   input  logic [7:0] lock_pair_i,
   output logic       lock_ack_o,
   output logic       lock_nack_o,
   input  logic       rel_req_i,
   input  logic [7:0] rel_pair_i,
   output logic       rel_ack_o,
   output logic       lock_full_o,
   output logic [4:0] locked_count_o,
   output logic       overrun_o
);

   logic [7:0] cur_pair_r;
   logic [7:0] succ_pair_s;
   logic [7:0] hist_pair_r;
   logic       hist_strb_r;
   logic       lock_nack_r;
   logic       advance_s;

   // The controller latches block_o on the ack edge, so bit 0 must follow wr_phase_i directly
   assign advance_s      = wr_ack_i & wr_phase_i;
   assign block_o        = {cur_pair_r, wr_phase_i};
   assign history_pair_o = hist_pair_r;
   assign history_strb_o = hist_strb_r;
   assign lock_nack_o    = lock_nack_r;

   // Current pair register, moved to the successor once the high half is consumed
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         cur_pair_r <= 8'd0;
      end else if (advance_s) begin
         cur_pair_r <= succ_pair_s;
      end else begin
         cur_pair_r <= cur_pair_r;
      end
   end

   // History report of the pair that was just completed
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         hist_pair_r <= 8'd0;
         hist_strb_r <= 1'b0;
      end else if (advance_s) begin
         hist_pair_r <= cur_pair_r;
         hist_strb_r <= 1'b1;
      end else begin
         hist_pair_r <= hist_pair_r;
         hist_strb_r <= 1'b0;
      end
   end

`ifdef IRS_BLOCK_MANAGER_LOCK_EN
   logic [7:0]            next_pair_r;
   logic                  next_ok_r;
   logic [LOCK_SLOTS-1:0] slot_valid_r;
   logic [7:0]            slot_pair_r [LOCK_SLOTS];
   logic [LOCK_SLOTS-1:0] rel_valid_s;
   logic [LOCK_SLOTS-1:0] free_sel_s;
   logic [LOCK_SLOTS-1:0] slot_valid_nxt_s;
   logic [7:0]            slot_pair_nxt_s [LOCK_SLOTS];
   logic                  cand_hit_s;
   logic                  lock_hit_s;
   logic                  free_found_s;
   logic                  lock_accept_s;
   logic                  cand_clear_s;
   logic [4:0]            count_nxt_s;
   logic [4:0]            count_r;
   logic                  lock_full_r;
   logic                  lock_ack_r;
   logic                  rel_ack_r;
   logic                  overrun_r;

   assign succ_pair_s    = next_pair_r;
   assign lock_ack_o     = lock_ack_r;
   assign rel_ack_o      = rel_ack_r;
   assign lock_full_o    = lock_full_r;
   assign locked_count_o = count_r;
   assign overrun_o      = overrun_r;

   // Parallel slot compare; release is folded in before the lock so a freed slot is reusable
   always_comb begin
      cand_hit_s       = 1'b0;
      lock_hit_s       = 1'b0;
      free_found_s     = 1'b0;
      rel_valid_s      = '0;
      free_sel_s       = '0;
      slot_valid_nxt_s = '0;
      count_nxt_s      = 5'd0;
      for (int i = 0; i < LOCK_SLOTS; i++) begin
         slot_pair_nxt_s[i] = slot_pair_r[i];
      end
      for (int i = 0; i < LOCK_SLOTS; i++) begin
         cand_hit_s     = cand_hit_s | (slot_valid_r[i] & (slot_pair_r[i] == next_pair_r));
         rel_valid_s[i] = slot_valid_r[i] & ~(rel_req_i & (slot_pair_r[i] == rel_pair_i));
         lock_hit_s     = lock_hit_s | (rel_valid_s[i] & (slot_pair_r[i] == lock_pair_i));
         free_sel_s[i]  = ~rel_valid_s[i] & ~free_found_s;
         free_found_s   = free_found_s | ~rel_valid_s[i];
      end
      lock_accept_s = lock_req_i & (lock_hit_s | free_found_s);
      cand_clear_s  = lock_accept_s & (lock_pair_i == next_pair_r);
      for (int i = 0; i < LOCK_SLOTS; i++) begin
         if (lock_req_i && !lock_hit_s && free_sel_s[i]) begin
            slot_valid_nxt_s[i] = 1'b1;
            slot_pair_nxt_s[i]  = lock_pair_i;
         end else begin
            slot_valid_nxt_s[i] = rel_valid_s[i];
            slot_pair_nxt_s[i]  = slot_pair_r[i];
         end
         count_nxt_s = count_nxt_s + {4'd0, slot_valid_nxt_s[i]};
      end
   end

   // Lock table and request responses
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         slot_valid_r <= '0;
         for (int i = 0; i < LOCK_SLOTS; i++) begin
            slot_pair_r[i] <= 8'd0;
         end
         lock_ack_r  <= 1'b0;
         lock_nack_r <= 1'b0;
         rel_ack_r   <= 1'b0;
         count_r     <= 5'd0;
         lock_full_r <= 1'b0;
      end else begin
         slot_valid_r <= slot_valid_nxt_s;
         for (int i = 0; i < LOCK_SLOTS; i++) begin
            slot_pair_r[i] <= slot_pair_nxt_s[i];
         end
         lock_ack_r  <= lock_accept_s;
         lock_nack_r <= lock_req_i & ~lock_accept_s;
         rel_ack_r   <= rel_req_i;
         count_r     <= count_nxt_s;
         lock_full_r <= &slot_valid_nxt_s;
      end
   end

   // Candidate search: one slot-compare step per non-advance cycle; a locked candidate at advance is overwritten
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         next_pair_r <= 8'd1;
         next_ok_r   <= 1'b0;
         overrun_r   <= 1'b0;
      end else if (advance_s) begin
         next_pair_r <= next_pair_r + 8'd1;
         next_ok_r   <= 1'b0;
         overrun_r   <= overrun_r | cand_hit_s;
      end else begin
         if (!next_ok_r && cand_hit_s) begin
            next_pair_r <= next_pair_r + 8'd1;
         end else begin
            next_pair_r <= next_pair_r;
         end
         next_ok_r <= ~cand_clear_s & (next_ok_r | ~cand_hit_s);
         overrun_r <= overrun_r;
      end
   end
`else
   logic [16:0] unused_req_s;
   logic [4:0]  unused_slots_s;

   assign succ_pair_s    = cur_pair_r + 8'd1;
   assign unused_req_s   = {lock_pair_i, rel_req_i, rel_pair_i};
   assign unused_slots_s = 5'(LOCK_SLOTS);
   assign lock_ack_o     = 1'b0;
   assign rel_ack_o      = 1'b0;
   assign lock_full_o    = 1'b0;
   assign locked_count_o = 5'd0;
   assign overrun_o      = 1'b0;

   // Without a lock table every lock request is refused
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         lock_nack_r <= 1'b0;
      end else begin
         lock_nack_r <= lock_req_i;
      end
   end
`endif

endmodule

// File: doc/irs_block_manager.md
# irs_block_manager

Supplies IRS write block addresses to the quad write controller and keeps recently written block pairs from being overwritten while they wait for readout. It drives the block-address inputs of the write controller and consumes that controller's `wr_phase`/`wr_ack` handshake. It also accepts lock and release requests from the trigger and readout logic, and reports each completed block pair to the history buffer.

## Interface
- `LOCK_SLOTS`, default 8: number of lockable pair entries, legal range 1–16.
- `clk_i` input 1: system clock, same clock as the write controller.
- `rst_n_i` input 1: reset, asynchronous, active-low.
- `wr_phase_i` input 1: write-controller phase; 0 selects the low half, 1 the high half.
- `wr_ack_i` input 1: write controller has taken `block_o` this cycle.
- `block_o` output 9: block address, equal to {cur_pair, wr_phase_i}.
- `history_pair_o` output 8: pair that has just been fully written.
- `history_strb_o` output 1: 1-cycle strobe qualifying `history_pair_o`.
- `lock_req_i` input 1: 1-cycle lock request.
- `lock_pair_i` input 8: pair to lock.
- `lock_ack_o` output 1: lock accepted, 1-cycle pulse.
- `lock_nack_o` output 1: lock refused because the table is full, 1-cycle pulse.
- `rel_req_i` input 1: 1-cycle release request.
- `rel_pair_i` input 8: pair to release.
- `rel_ack_o` output 1: release processed, 1-cycle pulse.
- `lock_full_o` output 1: all slots are valid.
- `locked_count_o` output 5: number of valid slots.
- `overrun_o` output 1: sticky; a locked pair was overwritten.

## Operation
- State registers:
  - `cur_pair[7:0]`, the pair being written.
  - `next_pair[7:0]`, the search candidate.
  - `next_ok`, set when the candidate has been verified free.
  - Lock table of LOCK_SLOTS entries, each {valid, pair[7:0]}.
- Pair advance happens on `wr_ack_i && wr_phase_i` (the high half was consumed):
  - `cur_pair` <= `next_pair`.
  - `next_pair` <= `next_pair`+1.
  - `next_ok` <= 0.
  - `history_pair_o` <= old `cur_pair`; `history_strb_o` pulses.
- An ack with `wr_phase_i`=0 changes no state.
- Search runs every non-advance cycle while `next_ok`=0:
  - If `next_pair` matches any valid slot, `next_pair` <= `next_pair`+1.
  - Otherwise `next_ok` <= 1.
  - The compare against all slots is parallel and takes one cycle.
- An accepted lock whose pair equals `next_pair` clears `next_ok`.
- Advance with an unverified candidate: if `next_pair` is locked at the moment of advance, the block still advances and `overrun_o` <= 1. This is the overwrite policy; the write controller is never stalled.
- Pair arithmetic is 8-bit modulo: 255+1 = 0.
- Lock request handling:
  - Already-valid pair: ack, no new slot (idempotent).
  - Free slot available: store in the lowest-index free slot, ack.
  - Table full: nack.
  - Locking `cur_pair` is legal; the lock only blocks future reuse.
- Release request handling:
  - Invalidate the matching slot.
  - `rel_ack_o` pulses whether or not a match exists.
- Same-cycle lock and release: the release is applied first, so a freed slot is usable by the lock. If both name the same pair, the net result is locked.

## Timing
- Upper bits of `block_o` come from a register. Bit 0 is combinational from `wr_phase_i`, so `block_o` is valid in the `wr_ack_i` cycle and the controller latches it on the same edge.
- Pair advances arrive every 4 clocks (acks are 2 clocks apart). That leaves 3 search cycles per pair, so a run of up to 3 consecutive locked pairs is skipped cleanly. A 4th consecutive locked pair is overwritten and sets `overrun_o`.
- `lock_ack_o`, `lock_nack_o` and `rel_ack_o` assert 1 clock after the request.
- `locked_count_o` and `lock_full_o` reflect the table state after that edge.
- `history_strb_o` asserts 1 clock after the advancing ack.
- Reset values:
  - `cur_pair`=0, `next_pair`=1, `next_ok`=0.
  - All slots invalid.
  - All outputs 0, except `block_o`={0, `wr_phase_i`}.
- An asserted reset mid-operation immediately clears the table, pairs and `overrun_o`. There is no pending-request memory.

## Configuration
- Macro `IRS_BLOCK_MANAGER_LOCK_EN`.
- Defined: lock table, search and overrun logic are built as described above.
- Undefined:
  - Pairs advance strictly sequentially (`next_pair` = `cur_pair`+1).
  - `lock_req_i`, `lock_pair_i`, `rel_req_i` and `rel_pair_i` are ignored.
  - `lock_nack_o` pulses 1 clock after every `lock_req_i`.
  - `lock_ack_o`, `rel_ack_o`, `lock_full_o`, `locked_count_o` and `overrun_o` are tied to 0.
  - History outputs are unchanged.

## Test plan
- Reset released, then acks alternating phase 0/1 every 2 clocks. Required: `block_o` = 0,1,2,3,4,5. `history_strb_o` with pairs 0, 1, 2.
- With `cur_pair`=1, lock pair 3. Required: `lock_ack_o` next clock, `locked_count_o`=1. Block sequence 2,3,4,5,8,9, no overrun.
- Lock 8 distinct pairs, then a 9th. Required: `lock_nack_o` on the 9th, `lock_full_o`=1, `locked_count_o`=8. Then release and lock in the same cycle: `rel_ack_o` and `lock_ack_o` both pulse and the count stays 8.
- With `cur_pair`=4, lock pairs 5,6,7. Required: next pair is 8, `overrun_o`=0. Repeat with 5–8 locked: `cur_pair` becomes 8 and `overrun_o`=1 (sticky).
- Run to `cur_pair`=255. Required: `block_o` goes 510, 511, then 0, 1, with `history_pair_o`=255.
- Assert `rst_n_i` low asynchronously between acks with 3 locks held. Required: all outputs 0 immediately, `locked_count_o`=0, and after release `block_o` restarts at 0.
